// File: rtl/imem_loader.sv
// imem_loader: byte-serial big-endian loader into instruction RAM with trailing XOR checksum check
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        checksum
);
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WRITE, CHECK, DONE, ERR} state_t;
  state_t state, nxt;
  logic acc, last, restart;
  assign acc = byte_valid && byte_ready;
  assign last = imem_addr == ADDR_W'(DEPTH - 1);
  assign restart = start && (state == IDLE || state == DONE || state == ERR);
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? LOAD_HI : state;
      LOAD_HI:         nxt = acc ? LOAD_LO : state;
      LOAD_LO:         nxt = acc ? WRITE : state;
      WRITE:           nxt = last ? CHECK : LOAD_HI;
      CHECK:           nxt = !acc ? state : (byte_in == checksum ? DONE : ERR);
      default:         nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      checksum   <= '0;
    end else begin
      state      <= nxt;
      byte_ready <= nxt == LOAD_HI || nxt == LOAD_LO || nxt == CHECK;
      imem_we    <= nxt == WRITE;
      cpu_hold   <= !(nxt == IDLE || nxt == DONE);
      if (restart) begin
        checksum  <= '0;
        imem_addr <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
      if (acc && state == LOAD_HI) begin
        imem_wdata[15:8] <= byte_in;
        checksum         <= checksum ^ byte_in;
      end
      if (acc && state == LOAD_LO) begin
        imem_wdata[7:0] <= byte_in;
        checksum        <= checksum ^ byte_in;
      end
      if (state == WRITE && !last) imem_addr <= imem_addr + 1'b1;
      if (acc && state == CHECK) begin
        load_done <= byte_in == checksum;
        load_err  <= byte_in != checksum;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized load streams checked against a word/checksum reference model
module tb_imem_loader;
  logic        clk = 0, rst = 1, start = 0, byte_valid = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_ready, imem_we, cpu_hold, load_done, load_err;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [7:0]  checksum;
  int n_checks = 0, n_fail = 0, wr_cnt = 0;
  logic [15:0] exp_words [16];
  logic [15:0] ram [16];

  imem_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (imem_we) begin
    check("we_ready", 32'(byte_ready), 0);
    if (wr_cnt < 16) begin
      check("we_addr", 32'(imem_addr), wr_cnt);
      check("we_data", 32'(imem_wdata), 32'(exp_words[wr_cnt]));
    end else check("extra_write", wr_cnt, 15);
    ram[imem_addr] = imem_wdata;
    wr_cnt++;
  end

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 0);
    check({tag, "_we"}, 32'(imem_we), 0);
    check({tag, "_hold"}, 32'(cpu_hold), 0);
    check({tag, "_done"}, 32'(load_done), 0);
    check({tag, "_err"}, 32'(load_err), 0);
    check({tag, "_addr"}, 32'(imem_addr), 0);
    check({tag, "_wdata"}, 32'(imem_wdata), 0);
    check({tag, "_csum"}, 32'(checksum), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int t = 0;
    if (thr) repeat ($urandom_range(0, 2)) begin
      byte_valid = 0;
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1;
    byte_in = b;
    while (!byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("ready_timeout", t, 0);
    else @(negedge clk);
    byte_valid = 0;
    byte_in = 8'($urandom);
  endtask

  task automatic fill(input logic [15:0] base, input bit rnd);
    for (int i = 0; i < 16; i++) exp_words[i] = rnd ? 16'($urandom) : base + 16'(i);
  endtask

  task automatic do_load(input logic [7:0] bad, input bit thr, input int mid, input int rst_at);
    logic [7:0] x = 0;
    wr_cnt = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_hold", 32'(cpu_hold), 1);
    check("start_done", 32'(load_done), 0);
    check("start_err", 32'(load_err), 0);
    check("start_csum", 32'(checksum), 0);
    check("start_addr", 32'(imem_addr), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == rst_at) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_idle("midrst");
        check("midrst_writes", wr_cnt, rst_at);
        return;
      end
      if (i == mid) begin
        start = 1;
        @(negedge clk);
        start = 0;
      end
      send_byte(exp_words[i][15:8], thr);
      send_byte(exp_words[i][7:0], thr);
      x ^= exp_words[i][15:8] ^ exp_words[i][7:0];
      check("csum_run", 32'(checksum), 32'(x));
    end
    send_byte(x ^ bad, thr);
    check("end_done", 32'(load_done), 32'(bad == 0));
    check("end_err", 32'(load_err), 32'(bad != 0));
    check("end_hold", 32'(cpu_hold), 32'(bad != 0));
    check("end_ready", 32'(byte_ready), 0);
    check("end_csum", 32'(checksum), 32'(x));
    check("end_writes", wr_cnt, 16);
    for (int i = 0; i < 16; i++) check("ram_word", 32'(ram[i]), 32'(exp_words[i]));
    repeat (2) @(negedge clk);
    check("hold_done", 32'(load_done), 32'(bad == 0));
    check("hold_err", 32'(load_err), 32'(bad != 0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 0;
    @(negedge clk);
    check_idle("idle");
    fill(16'h1000, 0);
    do_load(8'h00, 0, 99, 99);
    do_load(8'h5A, 0, 99, 99);
    do_load(8'h00, 1, 99, 99);
    do_load(8'h00, 0, 5, 99);
    do_load(8'h00, 0, 99, 7);
    do_load(8'h00, 0, 99, 99);
    fill(16'h2200, 0);
    do_load(8'h00, 0, 99, 99);
    fill(0, 1);
    do_load(8'h00, 1, 99, 99);
    fill(0, 1);
    do_load(8'($urandom_range(1, 255)), 1, 99, 99);
    start = 1;
    rst = 1;
    @(negedge clk);
    start = 0;
    rst = 0;
    check_idle("start_rst");
    @(negedge clk);
    check("start_rst_stay", 32'(cpu_hold), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
